// File: rtl/obuf_pkg.sv
// Shared types for the output buffer responder: FSM state encoding and word-width helper.
package obuf_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } obuf_state_e;

   localparam int OBUF_ARRAY_M_DFLT   = 8;
   localparam int OBUF_ACC_WIDTH_DFLT = 48;

   // One buffer word carries every accumulator lane of an array row.
   function automatic int obuf_word_w(input int array_m, input int acc_width);
      return array_m * acc_width;
   endfunction

endpackage

// File: rtl/obuf_ram.sv
// Single write port / single registered read port word memory, no reset.
// Optional macro OBUF_BYPASS_EN selects write-first collision behaviour (default: read-first).
module obuf_ram #(
   parameter int WORD_W = 384,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      if (re_i) begin
`ifdef OBUF_BYPASS_EN
         if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
         end else begin
            rdata_q <= mem[raddr_i];
         end
`else
         rdata_q <= mem[raddr_i];
`endif
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/obuf_responder.sv
// Output buffer responder: array read/write port, host drain channel and a sweeping clear FSM.
// Collision behaviour is selected by macro OBUF_BYPASS_EN inside obuf_ram.
module obuf_responder
   import obuf_pkg::*;
#(
   parameter int ARRAY_M         = OBUF_ARRAY_M_DFLT,
   parameter int ACC_WIDTH       = OBUF_ACC_WIDTH_DFLT,
   parameter int OBUF_ADDR_WIDTH = 10
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           sys_obuf_read_req,
   input  logic [OBUF_ADDR_WIDTH-1:0]     sys_obuf_read_addr,
   output logic [ARRAY_M*ACC_WIDTH-1:0]   obuf_read_data,
   input  logic                           sys_obuf_write_req,
   input  logic [OBUF_ADDR_WIDTH-1:0]     sys_obuf_write_addr,
   input  logic [ARRAY_M*ACC_WIDTH-1:0]   obuf_write_data,
   input  logic                           drain_req,
   input  logic [OBUF_ADDR_WIDTH-1:0]     drain_addr,
   output logic                           drain_ready,
   output logic                           drain_valid,
   output logic [ARRAY_M*ACC_WIDTH-1:0]   drain_data,
   input  logic                           clear_start,
   output logic                           clear_busy,
   output logic                           err_sticky
);

   localparam int WORD_W = obuf_word_w(ARRAY_M, ACC_WIDTH);
   localparam int ADDR_W = OBUF_ADDR_WIDTH;

   obuf_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              rd_pend_q, dr_pend_q;
   logic [WORD_W-1:0] rd_hold_q, dr_hold_q;

   logic              busy, sys_rd_ok, drain_acc;
   logic              ram_we, ram_re;
   logic [ADDR_W-1:0] ram_waddr, ram_raddr;
   logic [WORD_W-1:0] ram_wdata, ram_rdata;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ram_we    = 1'b0;
      ram_waddr = sys_obuf_write_addr;
      ram_wdata = obuf_write_data;
      case (state_q)
         IDLE: begin
            // A write arriving with clear_start still commits before the sweep starts.
            ram_we = sys_obuf_write_req;
            if (clear_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = cnt_q;
            ram_wdata = '0;
            cnt_d     = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d = IDLE;
            end
            if (sys_obuf_read_req || sys_obuf_write_req) begin
               err_d = 1'b1;
            end
         end
      endcase
   end

   assign busy        = (state_q == CLEAR);
   assign drain_ready = ~sys_obuf_read_req & ~busy;
   assign sys_rd_ok   = sys_obuf_read_req & ~busy;
   assign drain_acc   = drain_req & drain_ready;
   // Sys read and drain share the single read port; the sys read always wins.
   assign ram_re      = sys_rd_ok | drain_acc;
   assign ram_raddr   = sys_obuf_read_req ? sys_obuf_read_addr : drain_addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         rd_pend_q <= 1'b0;
         dr_pend_q <= 1'b0;
         rd_hold_q <= '0;
         dr_hold_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         rd_pend_q <= sys_rd_ok;
         dr_pend_q <= drain_acc;
         if (rd_pend_q) begin
            rd_hold_q <= ram_rdata;
         end
         if (dr_pend_q) begin
            dr_hold_q <= ram_rdata;
         end
      end
   end

   obuf_ram #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   // Fresh RAM data is shown in the response cycle; the hold register keeps it afterwards.
   assign obuf_read_data = rd_pend_q ? ram_rdata : rd_hold_q;
   assign drain_data     = dr_pend_q ? ram_rdata : dr_hold_q;
   assign drain_valid    = dr_pend_q;
   assign clear_busy     = busy;
   assign err_sticky     = err_q;

endmodule

// File: tb/tb_obuf_responder.sv
// Directed self-checking bench for obuf_responder (4 lanes x 16 bits, 16-word buffer).
module tb_obuf_responder;

   localparam int AM  = 4;
   localparam int AW  = 16;
   localparam int ADW = 4;
   localparam int W   = AM * AW;

   localparam logic [W-1:0] PAT_A = {16{4'hA}};
   localparam logic [W-1:0] PAT_3 = {16{4'h3}};
   localparam logic [W-1:0] PAT_D = {16{4'hD}};
   localparam logic [W-1:0] ONE   = 64'd1;
   localparam logic [W-1:0] TWO   = 64'd2;
`ifdef OBUF_BYPASS_EN
   localparam logic [W-1:0] EXP_RDW = TWO;
`else
   localparam logic [W-1:0] EXP_RDW = ONE;
`endif

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           sys_obuf_read_req;
   logic [ADW-1:0] sys_obuf_read_addr;
   logic [W-1:0]   obuf_read_data;
   logic           sys_obuf_write_req;
   logic [ADW-1:0] sys_obuf_write_addr;
   logic [W-1:0]   obuf_write_data;
   logic           drain_req;
   logic [ADW-1:0] drain_addr;
   logic           drain_ready;
   logic           drain_valid;
   logic [W-1:0]   drain_data;
   logic           clear_start;
   logic           clear_busy;
   logic           err_sticky;

   int n_assert = 0;
   int n_fail   = 0;
   int busy_cnt;

   always #5 clk = ~clk;

   obuf_responder #(
      .ARRAY_M         (AM),
      .ACC_WIDTH       (AW),
      .OBUF_ADDR_WIDTH (ADW)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .sys_obuf_read_req   (sys_obuf_read_req),
      .sys_obuf_read_addr  (sys_obuf_read_addr),
      .obuf_read_data      (obuf_read_data),
      .sys_obuf_write_req  (sys_obuf_write_req),
      .sys_obuf_write_addr (sys_obuf_write_addr),
      .obuf_write_data     (obuf_write_data),
      .drain_req           (drain_req),
      .drain_addr          (drain_addr),
      .drain_ready         (drain_ready),
      .drain_valid         (drain_valid),
      .drain_data          (drain_data),
      .clear_start         (clear_start),
      .clear_busy          (clear_busy),
      .err_sticky          (err_sticky)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      sys_obuf_read_req   = 1'b0;
      sys_obuf_read_addr  = '0;
      sys_obuf_write_req  = 1'b0;
      sys_obuf_write_addr = '0;
      obuf_write_data     = '0;
      drain_req           = 1'b0;
      drain_addr          = '0;
      clear_start         = 1'b0;
   endtask

   task automatic sys_write(input logic [ADW-1:0] a, input logic [W-1:0] d);
      sys_obuf_write_req  = 1'b1;
      sys_obuf_write_addr = a;
      obuf_write_data     = d;
      tick();
      sys_obuf_write_req  = 1'b0;
      $display("write addr %0d data %h", a, d);
   endtask

   task automatic sys_read(input logic [ADW-1:0] a);
      sys_obuf_read_req  = 1'b1;
      sys_obuf_read_addr = a;
      tick();
      sys_obuf_read_req  = 1'b0;
      $display("read addr %0d data %h", a, obuf_read_data);
   endtask

   initial begin
      idle_inputs();
      #2 reset = 1'b0;
      #10;
      check("rst_rdata", obuf_read_data, '0);
      check("rst_ddata", drain_data, '0);
      check("rst_dvalid", W'(drain_valid), '0);
      check("rst_busy", W'(clear_busy), '0);
      check("rst_err", W'(err_sticky), '0);
      check("rst_dready", W'(drain_ready), ONE);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // write then read back with one-cycle latency, then hold
      sys_write(4'd5, PAT_A);
      sys_read(4'd5);
      check("rd_a5", obuf_read_data, PAT_A);
      tick();
      check("rd_hold", obuf_read_data, PAT_A);

      // same-cycle read/write collision
      sys_write(4'd7, ONE);
      sys_obuf_write_req  = 1'b1;
      sys_obuf_write_addr = 4'd7;
      obuf_write_data     = TWO;
      sys_read(4'd7);
      check("rdw_a7", obuf_read_data, EXP_RDW);
      sys_read(4'd7);
      check("rd_after_w", obuf_read_data, TWO);

      // drain blocked by a sys read, accepted once the read drops
      sys_write(4'd3, PAT_3);
      sys_obuf_read_req  = 1'b1;
      sys_obuf_read_addr = 4'd5;
      drain_req          = 1'b1;
      drain_addr         = 4'd3;
      #1;
      check("dr_blocked", W'(drain_ready), '0);
      tick();
      check("dr_no_valid", W'(drain_valid), '0);
      check("dr_sysrd", obuf_read_data, PAT_A);
      sys_obuf_read_req = 1'b0;
      #1;
      check("dr_ready", W'(drain_ready), ONE);
      tick();
      drain_req = 1'b0;
      $display("drain addr 3 valid %0b data %h", drain_valid, drain_data);
      check("dr_valid", W'(drain_valid), ONE);
      check("dr_data", drain_data, PAT_3);
      tick();
      check("dr_pulse", W'(drain_valid), '0);
      check("dr_hold", drain_data, PAT_3);
      check("rd_hold2", obuf_read_data, PAT_A);

      // clear sweep with a dropped read and write in the middle
      check("err_pre", W'(err_sticky), '0);
      clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      busy_cnt = 0;
      for (int i = 0; i < 40 && clear_busy; i++) begin
         busy_cnt++;
         if (busy_cnt == 5) check("clr_dready", W'(drain_ready), '0);
         if (busy_cnt == 11) check("clr_rd_hold", obuf_read_data, PAT_A);
         if (busy_cnt == 10) begin
            sys_obuf_write_req  = 1'b1;
            sys_obuf_write_addr = 4'd2;
            obuf_write_data     = PAT_D;
            sys_obuf_read_req   = 1'b1;
            sys_obuf_read_addr  = 4'd7;
         end else begin
            sys_obuf_write_req = 1'b0;
            sys_obuf_read_req  = 1'b0;
         end
         tick();
      end
      sys_obuf_write_req = 1'b0;
      sys_obuf_read_req  = 1'b0;
      $display("clear busy cycles %0d", busy_cnt);
      check("clr_cycles", W'(busy_cnt), 64'd16);
      check("clr_err", W'(err_sticky), ONE);
      for (int a = 0; a < 16; a++) begin
         sys_read(ADW'(a));
         check($sformatf("clr_rd%0d", a), obuf_read_data, '0);
      end
      repeat (3) tick();
      check("err_sticky", W'(err_sticky), ONE);

      // write + clear_start together, then async reset at cnt=6
      sys_write(4'd4, PAT_A);
      sys_read(4'd4);
      sys_obuf_write_req  = 1'b1;
      sys_obuf_write_addr = 4'd9;
      obuf_write_data     = PAT_3;
      clear_start         = 1'b1;
      tick();
      sys_obuf_write_req = 1'b0;
      clear_start        = 1'b0;
      check("clr_start_w", W'(clear_busy), ONE);
      repeat (6) tick();
      #2 reset = 1'b0;
      #1;
      $display("async reset mid-clear busy %0b err %0b", clear_busy, err_sticky);
      check("ar_busy", W'(clear_busy), '0);
      check("ar_err", W'(err_sticky), '0);
      check("ar_dvalid", W'(drain_valid), '0);
      check("ar_rdata", obuf_read_data, '0);
      check("ar_ddata", drain_data, '0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check("post_idle", W'(clear_busy), '0);
      sys_write(4'd1, PAT_3);
      sys_read(4'd1);
      check("post_rd", obuf_read_data, PAT_3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
